// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizing for the FIFO stream reader.
// The checksum feature is enabled with the FRAME_CHECKSUM_EN macro.
package fifo_stream_pkg;

    localparam int SKID_DEPTH = 3;

    typedef enum logic {
        ST_DATA,
        ST_CKSUM
    } state_e;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream, seen from the reader (master)
// or from its environment (slave).
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;
    logic                  err_unexp;

    modport master (
        input  fifo_empty, fifo_valid, fifo_dout, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, err_unexp
    );

    modport slave (
        output fifo_empty, fifo_valid, fifo_dout, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, err_unexp
    );
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Three-entry circular prefetch buffer that absorbs the FIFO read latency.
// Caller guarantees no push when full and no pop when empty.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output occ_t                  occ_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [1:0]            wr_ptr_q;
    logic [1:0]            rd_ptr_q;
    occ_t                  occ_q;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // NOTE: storage is not reset; occupancy alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a standard sync FIFO into a framed valid/ready stream.
// Define FRAME_CHECKSUM_EN to append an XOR checksum beat to every frame.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    fifo_stream_reader_if.master bus
);

    localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

    occ_t                  occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;
    logic                  inflight_q;
    logic                  err_q;
    logic [15:0]           idx_q, idx_d;
    state_e                state_q, state_d;
`ifdef FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
`endif

    stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (push),
        .data_i (bus.fifo_dout),
        .pop_i  (pop),
        .head_o (head),
        .occ_o  (occ)
    );

    // Credit counts words held plus the one possibly in flight; m_ready never enters here.
    assign bus.fifo_rd_en = rst_n && !bus.fifo_empty
                          && ((3'(occ) + 3'(inflight_q)) < 3'(SKID_DEPTH));
    assign push          = bus.fifo_valid && inflight_q;
    assign bus.err_unexp = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            state_q    <= ST_DATA;
`ifdef FRAME_CHECKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            inflight_q <= bus.fifo_rd_en;
            if (bus.fifo_valid && !inflight_q) err_q <= 1'b1;
            idx_q      <= idx_d;
            state_q    <= state_d;
`ifdef FRAME_CHECKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        bus.m_valid = 1'b0;
        bus.m_data  = '0;
        bus.m_last  = 1'b0;
        pop         = 1'b0;
        idx_d       = idx_q;
        state_d     = state_q;
`ifdef FRAME_CHECKSUM_EN
        cksum_d     = cksum_q;
`endif
        case (state_q)
            ST_DATA: begin
                bus.m_valid = (occ != '0);
                bus.m_data  = bus.m_valid ? head : '0;
`ifndef FRAME_CHECKSUM_EN
                bus.m_last  = bus.m_valid && (idx_q == LAST_IDX);
`endif
                pop = bus.m_valid && bus.m_ready;
                if (pop) begin
`ifdef FRAME_CHECKSUM_EN
                    cksum_d = cksum_q ^ head;
                    if (idx_q == LAST_IDX) state_d = ST_CKSUM;
                    else                   idx_d   = idx_q + 16'd1;
`else
                    idx_d = (idx_q == LAST_IDX) ? 16'd0 : idx_q + 16'd1;
`endif
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CKSUM: begin
                bus.m_valid = 1'b1;
                bus.m_data  = cksum_q;
                bus.m_last  = 1'b1;
                if (bus.m_ready) begin
                    cksum_d = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
`endif
            default: state_d = ST_DATA;
        endcase
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO, cycle table, corner sequences.
module tb_fifo_stream_reader;
    import fifo_stream_pkg::*;

    localparam int DW = 8;
    localparam int FL = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural standard FIFO: one-cycle read latency, registered empty flag.
    logic [DW-1:0] fq[$];
    logic          mdl_valid = 1'b0;
    logic          mdl_empty = 1'b1;
    logic [DW-1:0] mdl_dout  = '0;
    logic          inj_valid = 1'b0;
    logic          rdy       = 1'b0;
    int            n_rd      = 0;

    assign bus.fifo_empty = mdl_empty;
    assign bus.fifo_valid = mdl_valid | inj_valid;
    assign bus.fifo_dout  = mdl_dout;
    assign bus.m_ready    = rdy;

    always @(posedge clk) begin
        if (!rst_n) begin
            fq.delete();
            mdl_valid <= 1'b0;
            mdl_dout  <= '0;
            mdl_empty <= 1'b1;
        end else begin
            if (bus.fifo_rd_en) begin
                check("fifo_underflow", 32'(fq.size() != 0), 32'd1);
                n_rd++;
                if (fq.size() != 0) mdl_dout <= fq.pop_front();
            end
            mdl_valid <= bus.fifo_rd_en;
            mdl_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard state
    logic [DW-1:0] exp_q[$];
    int            exp_idx   = 0;
    logic [DW-1:0] exp_ck    = '0;
    int            n_pop     = 0;
    logic [DW-1:0] next_val  = 8'h01;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic flush_model();
        exp_q.delete();
        exp_idx   = 0;
        exp_ck    = '0;
        n_pop     = 0;
        n_rd      = 0;
        next_val  = 8'h01;
        hold_prev = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(next_val);
            exp_q.push_back(next_val);
            next_val = next_val + 8'h01;
        end
    endtask

    // Called at a falling edge; hold rst_n low for the given number of rising edges.
    task automatic apply_reset(input int cycles);
        rst_n     = 1'b0;
        rdy       = 1'b0;
        inj_valid = 1'b0;
        for (int i = 0; i < cycles; i++) @(negedge clk);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_err", 32'(bus.err_unexp), 32'd0);
        rst_n = 1'b1;
        flush_model();
    endtask

    function automatic bit pending();
`ifdef FRAME_CHECKSUM_EN
        return (exp_q.size() != 0) || (exp_idx == FL);
`else
        return exp_q.size() != 0;
`endif
    endfunction

    // One cycle at a falling edge: check stability and any beat accepted at the next rising edge.
    task automatic step(input logic r);
        logic [DW-1:0] w;
        rdy = r;
        if (hold_prev) begin
            check("hold_valid", 32'(bus.m_valid), 32'd1);
            check("hold_data", 32'(bus.m_data), 32'(prev_data));
            check("hold_last", 32'(bus.m_last), 32'(prev_last));
        end
        if (bus.m_valid && r) begin
`ifdef FRAME_CHECKSUM_EN
            if (exp_idx == FL) begin
                check("cksum_data", 32'(bus.m_data), 32'(exp_ck));
                check("cksum_last", 32'(bus.m_last), 32'd1);
                exp_ck  = '0;
                exp_idx = 0;
            end else begin
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                check("beat_data", 32'(bus.m_data), 32'(w));
                check("beat_last", 32'(bus.m_last), 32'd0);
                exp_ck = exp_ck ^ w;
                exp_idx++;
                n_pop++;
            end
`else
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("beat_data", 32'(bus.m_data), 32'(w));
            check("beat_last", 32'(bus.m_last), 32'(exp_idx == FL - 1));
            exp_idx = (exp_idx == FL - 1) ? 0 : exp_idx + 1;
            n_pop++;
`endif
        end
        hold_prev = bus.m_valid && !r;
        prev_data = bus.m_data;
        prev_last = bus.m_last;
        check("credit_bound", 32'((n_rd - n_pop) <= SKID_DEPTH), 32'd1);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step(1'b1);
            n++;
        end
        check("drain_done", 32'(pending()), 32'd0);
    endtask

    typedef struct {
        logic          rdy;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_last;
        logic          exp_rd;
    } vec_t;

    vec_t vt[20];

    initial begin
        int cnt;
        int guard;

        // Cycle k is sampled at the falling edge after the k-th rising edge following the push.
        for (int k = 0; k < 20; k++) begin
            vt[k].rdy = 1'b1;
            vt[k].exp_rd = (k <= 15);
`ifdef FRAME_CHECKSUM_EN
            vt[k].exp_valid = (k >= 2 && k <= 18);
            vt[k].exp_data  = (k == 18) ? 8'h10 : 8'(k - 1);
            vt[k].exp_last  = (k == 18);
`else
            vt[k].exp_valid = (k >= 2 && k <= 17);
            vt[k].exp_data  = 8'(k - 1);
            vt[k].exp_last  = (k == 17);
`endif
        end

        // Frame of 0x01..0x10 at full rate
        apply_reset(2);
        push_words(16);
        for (int k = 0; k < 20; k++) begin
            rdy = vt[k].rdy;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t1_valid[%0d]", k), 32'(bus.m_valid), 32'(vt[k].exp_valid));
            check($sformatf("t1_rd_en[%0d]", k), 32'(bus.fifo_rd_en), 32'(vt[k].exp_rd));
            if (vt[k].exp_valid) begin
                check($sformatf("t1_data[%0d]", k), 32'(bus.m_data), 32'(vt[k].exp_data));
                check($sformatf("t1_last[%0d]", k), 32'(bus.m_last), 32'(vt[k].exp_last));
            end
        end

        // 40 words with m_ready toggling every cycle
        apply_reset(2);
        push_words(40);
        guard = 0;
        while (pending() && guard < 300) begin
            step(guard % 2 == 0);
            guard++;
        end
        check("t3_all_out", 32'(pending()), 32'd0);
        check("t3_pop_count", 32'(n_pop), 32'd40);

        // Stalled consumer: exactly SKID_DEPTH reads, then resume
        apply_reset(2);
        push_words(10);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fifo_rd_en) cnt++;
            step(1'b0);
        end
        check("t4_reads_while_stalled", 32'(cnt), 32'(SKID_DEPTH));
        drain(100);
        check("t4_pop_count", 32'(n_pop), 32'd10);

        // Unexpected fifo_valid with nothing in flight
        for (int i = 0; i < 4; i++) step(1'b1);
        check("t5_err_before", 32'(bus.err_unexp), 32'd0);
        inj_valid = 1'b1;
        step(1'b1);
        inj_valid = 1'b0;
        check("t5_err_set", 32'(bus.err_unexp), 32'd1);
        check("t5_no_beat", 32'(bus.m_valid), 32'd0);
        push_words(5);
        drain(50);
        check("t5_err_sticky", 32'(bus.err_unexp), 32'd1);

        // Reset mid-frame at idx 7 with the buffer full
        apply_reset(2);
        push_words(20);
        guard = 0;
        while (n_pop < 7 && guard < 50) begin
            step(1'b1);
            guard++;
        end
        check("t6_reached_idx7", 32'(n_pop), 32'd7);
        for (int i = 0; i < 6; i++) step(1'b0);
        check("t6_full_no_read", 32'(bus.fifo_rd_en), 32'd0);
        check("t6_full_valid", 32'(bus.m_valid), 32'd1);
        apply_reset(1);
        push_words(16);
        drain(60);
        check("t6_frame_done", 32'(n_pop), 32'd16);
        check("t6_idx_wrapped", 32'(exp_idx), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
